// File: rtl/result_hex_display.sv
// Result word to six active-low seven-segment digits, in hex or in decimal
// via iterative double-dabble, with optional leading-zero blanking.
module result_hex_display #(
    parameter int DATA_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              mode_dec,
    input  logic              blank_lz,
    output logic              busy,
    output logic              disp_valid,
    output logic [6:0]        HEX0,
    output logic [6:0]        HEX1,
    output logic [6:0]        HEX2,
    output logic [6:0]        HEX3,
    output logic [6:0]        HEX4,
    output logic [6:0]        HEX5
);

    localparam int SH_W = 24 + DATA_W;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_t;

    state_t           state;
    logic [SH_W-1:0]  shift_q;
    logic [4:0]       cnt;
    logic             mode_q;
    logic             blank_q;
    logic             ovf_q;
    logic [5:0][6:0]  hex_q;
    logic [5:0][6:0]  hex_next;
    logic [5:0][3:0]  dig;
    logic [23:0]      hex_val;
    int unsigned      msd;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'h0: glyph = 7'b1000000;
            4'h1: glyph = 7'b1111001;
            4'h2: glyph = 7'b0100100;
            4'h3: glyph = 7'b0110000;
            4'h4: glyph = 7'b0011001;
            4'h5: glyph = 7'b0010010;
            4'h6: glyph = 7'b0000010;
            4'h7: glyph = 7'b1111000;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0010000;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b0000011;
            4'hC: glyph = 7'b1000110;
            4'hD: glyph = 7'b0100001;
            4'hE: glyph = 7'b0000110;
            default: glyph = 7'b0001110;
        endcase
    endfunction

    function automatic logic [SH_W-1:0] dabble_step(input logic [SH_W-1:0] s);
        logic [SH_W-1:0] t;
        t = s;
        for (int unsigned d = 0; d < 6; d++) begin
            if (t[DATA_W+4*d +: 4] >= 4'd5)
                t[DATA_W+4*d +: 4] = t[DATA_W+4*d +: 4] + 4'd3;
        end
        return {t[SH_W-2:0], 1'b0};
    endfunction

    // Hex digits come from the raw word still sitting in the low half of the
    // shift register; decimal digits come from the converted BCD upper half.
    always_comb begin
        hex_val  = 24'(shift_q[DATA_W-1:0]);
        dig      = '0;
        hex_next = '1;
        msd      = 0;
        for (int unsigned d = 0; d < 6; d++) begin
            dig[d] = mode_q ? shift_q[DATA_W+4*d +: 4] : hex_val[4*d +: 4];
            if (dig[d] != 4'd0)
                msd = d;
        end
        for (int unsigned d = 0; d < 6; d++) begin
            if (ovf_q)
                hex_next[d] = SEG_DASH;
            else if (blank_q && d > msd)
                hex_next[d] = SEG_BLANK;
            else
                hex_next[d] = glyph(dig[d]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            busy       <= 1'b0;
            disp_valid <= 1'b0;
            hex_q      <= '1;
            shift_q    <= '0;
            cnt        <= '0;
            mode_q     <= 1'b0;
            blank_q    <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shift_q  <= {24'b0, in_data};
                        mode_q   <= mode_dec;
                        blank_q  <= blank_lz;
                        ovf_q    <= mode_dec && (24'(in_data) > 24'd999999);
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= mode_dec ? CONVERT : UPDATE;
                    end
                end
                CONVERT: begin
                    shift_q <= dabble_step(shift_q);
                    cnt     <= cnt + 5'd1;
                    if (cnt == 5'(DATA_W - 1))
                        state <= UPDATE;
                end
                UPDATE: begin
                    hex_q      <= hex_next;
                    disp_valid <= 1'b1;
                    in_ready   <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign HEX0 = hex_q[0];
    assign HEX1 = hex_q[1];
    assign HEX2 = hex_q[2];
    assign HEX3 = hex_q[3];
    assign HEX4 = hex_q[4];
    assign HEX5 = hex_q[5];

endmodule

// File: tb/tb_result_hex_display.sv
// Bench for result_hex_display: directed vector table, reset-abort sequence,
// and randomized words checked against an arithmetic digit model.
module tb_result_hex_display;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        mode_dec;
    logic        blank_lz;
    logic        busy;
    logic        disp_valid;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

    int checks = 0;
    int errors = 0;

    localparam logic [6:0] BL = 7'h7F;
    localparam logic [6:0] DS = 7'b0111111;
    localparam logic [6:0] GLYPH [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    typedef struct {
        logic [23:0] data;
        logic        mode;
        logic        blank;
        logic [41:0] exp_hex;
    } vec_t;

    vec_t vecs[14];

    result_hex_display #(.DATA_W(24)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mode_dec(mode_dec), .blank_lz(blank_lz),
        .busy(busy), .disp_valid(disp_valid),
        .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5)
    );

    always #5 clk = ~clk;

    function automatic logic [41:0] hex_all();
        return {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
    endfunction

    function automatic logic [41:0] p6(input logic [6:0] h5, h4, h3, h2, h1, h0);
        return {h5, h4, h3, h2, h1, h0};
    endfunction

    // Digits from plain division/modulo of the value, most significant nonzero digit found by scan.
    function automatic logic [41:0] model(input int unsigned value, input logic m, input logic b);
        int unsigned v;
        int unsigned dg[6];
        int          top;
        logic [41:0] r;
        if (m && value > 999999) return {6{DS}};
        v = value;
        for (int i = 0; i < 6; i++) begin
            dg[i] = m ? v % 10 : v % 16;
            v     = m ? v / 10 : v / 16;
        end
        top = 0;
        for (int i = 0; i < 6; i++)
            if (dg[i] != 0) top = i;
        for (int i = 0; i < 6; i++)
            r[7*i +: 7] = (b && i > top) ? BL : GLYPH[dg[i]];
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Presents one word, accepts it, scrambles the inputs, and measures busy cycles.
    task automatic send(input logic [23:0] d, input logic m, input logic b,
                        output int lat, output logic rdy_bad);
        @(negedge clk);
        in_data = d; mode_dec = m; blank_lz = b; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 24'($urandom);
        mode_dec = ~m;
        blank_lz = ~b;
        lat = 0;
        rdy_bad = 1'b0;
        while (busy && lat < 100) begin
            if (in_ready) rdy_bad = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_vec(input string tag, input logic [23:0] d, input logic m,
                           input logic b, input logic [41:0] exp);
        int   lat;
        logic rb;
        send(d, m, b, lat, rb);
        chk({tag, "_latency"}, 64'(lat), m ? 64'd25 : 64'd1);
        chk({tag, "_ready_low"}, 64'(rb), 64'd0);
        chk({tag, "_hex"}, 64'(hex_all()), 64'(exp));
        chk({tag, "_disp_valid"}, 64'(disp_valid), 64'd1);
        chk({tag, "_ready_back"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        vecs[0]  = '{24'h00A3F1, 1'b0, 1'b1, p6(BL, BL, GLYPH[10], GLYPH[3], GLYPH[15], GLYPH[1])};
        vecs[1]  = '{24'd123456, 1'b1, 1'b0, p6(GLYPH[1], GLYPH[2], GLYPH[3], GLYPH[4], GLYPH[5], GLYPH[6])};
        vecs[2]  = '{24'd1000000, 1'b1, 1'b1, {6{DS}}};
        vecs[3]  = '{24'd999999, 1'b1, 1'b1, {6{GLYPH[9]}}};
        vecs[4]  = '{24'd0, 1'b0, 1'b1, p6(BL, BL, BL, BL, BL, GLYPH[0])};
        vecs[5]  = '{24'd0, 1'b0, 1'b0, {6{GLYPH[0]}}};
        vecs[6]  = '{24'd0, 1'b1, 1'b1, p6(BL, BL, BL, BL, BL, GLYPH[0])};
        vecs[7]  = '{24'd0, 1'b1, 1'b0, {6{GLYPH[0]}}};
        vecs[8]  = '{24'hFFFFFF, 1'b0, 1'b0, {6{GLYPH[15]}}};
        vecs[9]  = '{24'd42, 1'b1, 1'b1, p6(BL, BL, BL, BL, GLYPH[4], GLYPH[2])};
        vecs[10] = '{24'h100000, 1'b0, 1'b1, p6(GLYPH[1], GLYPH[0], GLYPH[0], GLYPH[0], GLYPH[0], GLYPH[0])};
        vecs[11] = '{24'hFFFFFF, 1'b1, 1'b0, {6{DS}}};
        vecs[12] = '{24'd1000, 1'b1, 1'b1, p6(BL, BL, GLYPH[1], GLYPH[0], GLYPH[0], GLYPH[0])};
        vecs[13] = '{24'h0B0D0E, 1'b0, 1'b1, p6(BL, GLYPH[11], GLYPH[0], GLYPH[13], GLYPH[0], GLYPH[14])};

        rst = 1'b1; in_data = '0; in_valid = 1'b0; mode_dec = 1'b0; blank_lz = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_hex", 64'(hex_all()), 64'(p6(BL, BL, BL, BL, BL, BL)));
        chk("reset_ready", 64'(in_ready), 64'd1);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_disp_valid", 64'(disp_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Reset during a decimal conversion while the next word waits upstream.
        begin
            int lat;
            @(negedge clk);
            in_data = 24'd42; mode_dec = 1'b1; blank_lz = 1'b1; in_valid = 1'b1;
            @(posedge clk);
            #1;
            chk("abort_busy_after_accept", 64'(busy), 64'd1);
            in_data = 24'd777; mode_dec = 1'b1; blank_lz = 1'b0;
            repeat (9) @(posedge clk);
            #1;
            chk("abort_ready_while_busy", 64'(in_ready), 64'd0);
            chk("abort_hex_before_rst", 64'(hex_all()), 64'(p6(BL, BL, BL, BL, BL, BL)));
            @(negedge clk);
            rst = 1'b1;
            @(posedge clk);
            #1;
            chk("abort_hex_after_rst", 64'(hex_all()), 64'(p6(BL, BL, BL, BL, BL, BL)));
            chk("abort_ready_after_rst", 64'(in_ready), 64'd1);
            chk("abort_busy_after_rst", 64'(busy), 64'd0);
            chk("abort_disp_valid", 64'(disp_valid), 64'd0);
            @(negedge clk);
            rst = 1'b0;
            @(posedge clk);
            #1;
            chk("abort_second_accepted", 64'(busy), 64'd1);
            in_valid = 1'b0;
            in_data  = 24'd5;
            lat = 0;
            while (busy && lat < 100) begin
                @(posedge clk);
                #1;
                lat++;
            end
            chk("abort_second_latency", 64'(lat), 64'd25);
            chk("abort_second_hex", 64'(hex_all()), 64'(model(777, 1'b1, 1'b0)));
            chk("abort_second_disp_valid", 64'(disp_valid), 64'd1);
        end

        foreach (vecs[i])
            run_vec($sformatf("vec%0d", i), vecs[i].data, vecs[i].mode, vecs[i].blank, vecs[i].exp_hex);

        for (int n = 0; n < 40; n++) begin
            logic [23:0] d;
            logic        m, b;
            int unsigned sel;
            sel = $urandom_range(0, 3);
            case (sel)
                0: d = 24'($urandom_range(0, 99));
                1: d = 24'($urandom_range(0, 999999));
                2: d = 24'($urandom_range(999990, 1000010));
                default: d = 24'($urandom);
            endcase
            m = 1'($urandom);
            b = 1'($urandom);
            run_vec($sformatf("rand%0d", n), d, m, b, model(int'(d), m, b));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
